// File: rtl/truth_table_checker.sv
// Sweeps all 8 input vectors of a 3-input combinational DUT and compares its response to a golden table.
// Optional macro TT_CHECKER_CAPTURE_EN adds a register that captures the observed truth table.
module truth_table_checker #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic [2:0] vec_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] mismatch_cnt,
    output logic       fail_found,
    output logic [2:0] first_fail,
    output logic [7:0] observed
);

    // state  | meaning
    // IDLE   | waiting for start, results held
    // SETTLE | vec_out driven, waiting for the DUT to settle
    // SAMPLE | one cycle: compare dut_out with expected[vec_out]
    // DONE   | one cycle: done pulse, pass valid
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic [7:0] exp_q;
    logic       miss;
    logic [3:0] cnt_next;

    // The final sample's mismatch must count toward pass in the same edge that enters DONE.
    assign miss     = (dut_out != exp_q[vec_out]);
    assign cnt_next = mismatch_cnt + {3'b000, miss};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            settle_cnt   <= 4'd0;
            exp_q        <= 8'h00;
            vec_out      <= 3'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= 4'd0;
            fail_found   <= 1'b0;
            first_fail   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        exp_q        <= expected;
                        vec_out      <= 3'd0;
                        settle_cnt   <= SETTLE_LOAD;
                        mismatch_cnt <= 4'd0;
                        fail_found   <= 1'b0;
                        first_fail   <= 3'd0;
                        busy         <= 1'b1;
                        state        <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    mismatch_cnt <= cnt_next;
                    if (miss && !fail_found) begin
                        fail_found <= 1'b1;
                        first_fail <= vec_out;
                    end
                    if (vec_out == 3'd7) begin
                        done  <= 1'b1;
                        pass  <= (cnt_next == 4'd0);
                        state <= DONE;
                    end else begin
                        vec_out    <= vec_out + 3'd1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TT_CHECKER_CAPTURE_EN
    logic [7:0] obs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            obs_q <= 8'h00;
        end else if (state == IDLE && start) begin
            obs_q <= 8'h00;
        end else if (state == SAMPLE) begin
            obs_q[vec_out] <= dut_out;
        end
    end

    assign observed = obs_q;
`else
    assign observed = 8'h00;
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench for truth_table_checker: stimulus pushes expected sweep results, a monitor checks them at done.
module tb_truth_table_checker;

    localparam int unsigned SETTLE = 4;
    localparam int LAT = 8 * (SETTLE + 1);
`ifdef TT_CHECKER_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] expected = 8'h00;
    logic       dut_out;
    logic [2:0] vec_out;
    logic       busy, done, pass, fail_found;
    logic [3:0] mismatch_cnt;
    logic [2:0] first_fail;
    logic [7:0] observed;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mode = 0;

    typedef struct {
        int         start_edge;
        logic       pass;
        logic [3:0] cnt;
        logic       ff;
        logic [2:0] first;
        logic [7:0] obs;
    } exp_t;
    exp_t sb[$];

    truth_table_checker #(.SETTLE_CYCLES(SETTLE)) u_dut (
        .clk(clk), .rst(rst), .start(start), .expected(expected), .dut_out(dut_out),
        .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .fail_found(fail_found),
        .first_fail(first_fail), .observed(observed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational DUT stand-in: x=vec_out[0], y=vec_out[1], z=vec_out[2]
    always_comb begin
        logic x, y, z, f;
        x = vec_out[0];
        y = vec_out[1];
        z = vec_out[2];
        f = (x | y) & (~x | z);
        case (mode)
            0:       dut_out = f;
            1:       dut_out = f & (y | z);
            default: dut_out = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done actual=1 required=0 at edge %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_latency", cyc - e.start_edge, LAT);
                chk("pass", pass, e.pass);
                chk("mismatch_cnt", mismatch_cnt, e.cnt);
                chk("fail_found", fail_found, e.ff);
                if (e.ff) chk("first_fail", first_fail, e.first);
                chk("observed", observed, e.obs);
                chk("busy_in_done", busy, 1'b1);
            end
        end
    end

    task automatic issue(input logic [7:0] tbl, input logic p, input logic [3:0] n,
                         input logic ff, input logic [2:0] first, input logic [7:0] obs);
        exp_t e;
        expected = tbl;
        start = 1'b1;
        e.start_edge = cyc + 1;
        e.pass = p;
        e.cnt = n;
        e.ff = ff;
        e.first = first;
        e.obs = CAP ? obs : 8'h00;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=pending required=done", name);
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_vec_out"}, vec_out, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_pass"}, pass, 0);
        chk({name, "_mismatch_cnt"}, mismatch_cnt, 0);
        chk({name, "_fail_found"}, fail_found, 0);
        chk({name, "_first_fail"}, first_fail, 0);
        chk({name, "_observed"}, observed, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_zero("reset");

        // correct DUT
        mode = 0;
        issue(8'hE4, 1'b1, 4'd0, 1'b0, 3'd0, 8'hE4);
        repeat (5) @(posedge clk);
        #1;
        chk("busy_mid_sweep", busy, 1'b1);
        chk("done_mid_sweep", done, 1'b0);
        drain("correct");
        chk("busy_idle", busy, 1'b0);

        // consensus-term equivalent DUT
        mode = 1;
        issue(8'hE4, 1'b1, 4'd0, 1'b0, 3'd0, 8'hE4);
        drain("consensus");

        // output stuck at 0: mismatches on vectors 2,5,6,7
        mode = 2;
        issue(8'hE4, 1'b0, 4'd4, 1'b1, 3'd2, 8'h00);
        drain("stuck0");
        repeat (10) @(posedge clk);
        #1;
        chk("hold_mismatch_cnt", mismatch_cnt, 4'd4);
        chk("hold_fail_found", fail_found, 1'b1);
        chk("hold_first_fail", first_fail, 3'd2);
        chk("hold_pass", pass, 1'b0);

        // wrong golden table: first mismatch at vector 0, and all eight mismatching
        mode = 0;
        issue(8'hFF, 1'b0, 4'd4, 1'b1, 3'd0, 8'hE4);
        drain("golden_ff");
        issue(8'h1B, 1'b0, 4'd8, 1'b1, 3'd0, 8'hE4);
        drain("golden_inv");

        // start and expected changes while busy are ignored
        issue(8'hE4, 1'b1, 4'd0, 1'b0, 3'd0, 8'hE4);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        expected = 8'h00;
        @(posedge clk);
        #1 start = 1'b0;
        drain("restart_ignored");
        repeat (50) @(posedge clk);
        #1;

        // reset mid-sweep aborts with no done; start right after reset runs normally
        mode = 0;
        expected = 8'hE4;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("midreset");
        rst = 1'b0;
        issue(8'hE4, 1'b1, 4'd0, 1'b0, 3'd0, 8'hE4);
        drain("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
